// File: rtl/alu_ctrl_stage_if.sv
// Handshake bundle between the ID-side producer and the alu_ctrl_stage.
// The master side offers instructions and accepts decoded entries; the slave
// side is the stage itself.
//
// Valid/ready contract, both directions: a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised, its payload
// stays stable until that transfer. Ready may be given without a pending
// valid. in_ready comes straight from a register and never depends
// combinationally on out_ready.
interface alu_ctrl_stage_if #(
    parameter int CTRL_W = 8,
    parameter int TAG_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_alucontrol;
    logic              out_ri;
    logic              out_is_branch;
    logic              out_is_mem;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_alucontrol, out_ri,
               out_is_branch, out_is_mem, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_alucontrol, out_ri,
               out_is_branch, out_is_mem, out_tag
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decode stage between ID and EXE.
// Decodes a 32-bit MIPS word into an EXE operation code plus reserved and
// class flags, then hands it to EXE through a 2-entry skid buffer
// (main register M drives the outputs, skid register S catches the one
// entry that arrives after EXE stalls). in_ready is purely registered.
module alu_ctrl_stage #(
    parameter int CTRL_W        = 8,
    parameter int TAG_W         = 32,
    parameter bit DECODE_REGIMM = 1'b1,
    parameter bit DECODE_COP0   = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    alu_ctrl_stage_if.slave bus,
    output logic [1:0]      o_dbg_state
);

    // EXE operation codes (8-bit encodings shared with the EXE stage)
    localparam logic [7:0] EXE_NOP_OP     = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP     = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP      = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP     = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP     = 8'b00100111;
    localparam logic [7:0] EXE_ANDI_OP    = 8'b01011001;
    localparam logic [7:0] EXE_ORI_OP     = 8'b01011010;
    localparam logic [7:0] EXE_XORI_OP    = 8'b01011011;
    localparam logic [7:0] EXE_LUI_OP     = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP     = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP    = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP     = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP    = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP     = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP    = 8'b00000111;
    localparam logic [7:0] EXE_MFHI_OP    = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP    = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP    = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP    = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP     = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP    = 8'b00101011;
    localparam logic [7:0] EXE_SLTI_OP    = 8'b01010111;
    localparam logic [7:0] EXE_SLTIU_OP   = 8'b01011000;
    localparam logic [7:0] EXE_ADD_OP     = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP    = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP     = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP    = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP    = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP   = 8'b01010110;
    localparam logic [7:0] EXE_MULT_OP    = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP   = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP     = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP    = 8'b00011011;
    localparam logic [7:0] EXE_J_OP       = 8'b01001111;
    localparam logic [7:0] EXE_JAL_OP     = 8'b01010000;
    localparam logic [7:0] EXE_JALR_OP    = 8'b00001001;
    localparam logic [7:0] EXE_JR_OP      = 8'b00001000;
    localparam logic [7:0] EXE_BEQ_OP     = 8'b01010001;
    localparam logic [7:0] EXE_BGEZ_OP    = 8'b01000001;
    localparam logic [7:0] EXE_BGEZAL_OP  = 8'b01001011;
    localparam logic [7:0] EXE_BGTZ_OP    = 8'b01010100;
    localparam logic [7:0] EXE_BLEZ_OP    = 8'b01010011;
    localparam logic [7:0] EXE_BLTZ_OP    = 8'b01000000;
    localparam logic [7:0] EXE_BLTZAL_OP  = 8'b01001010;
    localparam logic [7:0] EXE_BNE_OP     = 8'b01010010;
    localparam logic [7:0] EXE_LB_OP      = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP     = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP      = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP     = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP      = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP      = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP      = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP      = 8'b11101011;
    localparam logic [7:0] EXE_SYSCALL_OP = 8'b00001100;
    localparam logic [7:0] EXE_BREAK_OP   = 8'b00001101;
    localparam logic [7:0] EXE_MFC0_OP    = 8'b01011101;
    localparam logic [7:0] EXE_MTC0_OP    = 8'b01100000;
    localparam logic [7:0] EXE_ERET_OP    = 8'b01101011;

    localparam logic [31:0] ERET_WORD = 32'h42000018;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              ri;
        logic              br;
        logic              mem;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic [7:0] w_code;
    logic       w_ri;
    logic       w_br;
    logic       w_mem;
    entry_t     w_dec;
    logic       w_accept;
    logic       w_drain;

    state_t     r_state;
    logic       r_m_valid;
    logic       r_s_valid;
    entry_t     r_m;
    entry_t     r_s;

    assign w_op    = bus.in_instr[31:26];
    assign w_rs    = bus.in_instr[25:21];
    assign w_rt    = bus.in_instr[20:16];
    assign w_funct = bus.in_instr[5:0];

    // Pure decode of the offered word; everything unrecognised becomes a reserved NOP
    always_comb begin
        w_code = EXE_NOP_OP;
        w_ri   = 1'b0;
        w_br   = 1'b0;
        w_mem  = 1'b0;
        if (bus.in_instr != 32'h0) begin
            case (w_op)
                6'b000000: begin
                    case (w_funct)
                        6'b000000: w_code = EXE_SLL_OP;
                        6'b000010: w_code = EXE_SRL_OP;
                        6'b000011: w_code = EXE_SRA_OP;
                        6'b000100: w_code = EXE_SLLV_OP;
                        6'b000110: w_code = EXE_SRLV_OP;
                        6'b000111: w_code = EXE_SRAV_OP;
                        6'b001000: begin w_code = EXE_JR_OP;   w_br = 1'b1; end
                        6'b001001: begin w_code = EXE_JALR_OP; w_br = 1'b1; end
                        6'b001100: w_code = EXE_SYSCALL_OP;
                        6'b001101: w_code = EXE_BREAK_OP;
                        6'b010000: w_code = EXE_MFHI_OP;
                        6'b010001: w_code = EXE_MTHI_OP;
                        6'b010010: w_code = EXE_MFLO_OP;
                        6'b010011: w_code = EXE_MTLO_OP;
                        6'b011000: w_code = EXE_MULT_OP;
                        6'b011001: w_code = EXE_MULTU_OP;
                        6'b011010: w_code = EXE_DIV_OP;
                        6'b011011: w_code = EXE_DIVU_OP;
                        6'b100000: w_code = EXE_ADD_OP;
                        6'b100001: w_code = EXE_ADDU_OP;
                        6'b100010: w_code = EXE_SUB_OP;
                        6'b100011: w_code = EXE_SUBU_OP;
                        6'b100100: w_code = EXE_AND_OP;
                        6'b100101: w_code = EXE_OR_OP;
                        6'b100110: w_code = EXE_XOR_OP;
                        6'b100111: w_code = EXE_NOR_OP;
                        6'b101010: w_code = EXE_SLT_OP;
                        6'b101011: w_code = EXE_SLTU_OP;
                        default:   w_ri   = 1'b1;
                    endcase
                end
                6'b000001: begin
                    if (DECODE_REGIMM) begin
                        case (w_rt)
                            5'b00000: begin w_code = EXE_BLTZ_OP;   w_br = 1'b1; end
                            5'b00001: begin w_code = EXE_BGEZ_OP;   w_br = 1'b1; end
                            5'b10000: begin w_code = EXE_BLTZAL_OP; w_br = 1'b1; end
                            5'b10001: begin w_code = EXE_BGEZAL_OP; w_br = 1'b1; end
                            default:  w_ri = 1'b1;
                        endcase
                    end else begin
                        w_ri = 1'b1;
                    end
                end
                6'b000010: begin w_code = EXE_J_OP;    w_br = 1'b1; end
                6'b000011: begin w_code = EXE_JAL_OP;  w_br = 1'b1; end
                6'b000100: begin w_code = EXE_BEQ_OP;  w_br = 1'b1; end
                6'b000101: begin w_code = EXE_BNE_OP;  w_br = 1'b1; end
                6'b000110: begin w_code = EXE_BLEZ_OP; w_br = 1'b1; end
                6'b000111: begin w_code = EXE_BGTZ_OP; w_br = 1'b1; end
                6'b001000: w_code = EXE_ADDI_OP;
                6'b001001: w_code = EXE_ADDIU_OP;
                6'b001010: w_code = EXE_SLTI_OP;
                6'b001011: w_code = EXE_SLTIU_OP;
                6'b001100: w_code = EXE_ANDI_OP;
                6'b001101: w_code = EXE_ORI_OP;
                6'b001110: w_code = EXE_XORI_OP;
                6'b001111: w_code = EXE_LUI_OP;
                6'b010000: begin
                    if (DECODE_COP0) begin
                        if (bus.in_instr == ERET_WORD) begin
                            w_code = EXE_ERET_OP;
                        end else if (w_rs == 5'b00000) begin
                            w_code = EXE_MFC0_OP;
                        end else if (w_rs == 5'b00100) begin
                            w_code = EXE_MTC0_OP;
                        end else begin
                            w_ri = 1'b1;
                        end
                    end else begin
                        w_ri = 1'b1;
                    end
                end
                6'b100000: begin w_code = EXE_LB_OP;  w_mem = 1'b1; end
                6'b100001: begin w_code = EXE_LH_OP;  w_mem = 1'b1; end
                6'b100011: begin w_code = EXE_LW_OP;  w_mem = 1'b1; end
                6'b100100: begin w_code = EXE_LBU_OP; w_mem = 1'b1; end
                6'b100101: begin w_code = EXE_LHU_OP; w_mem = 1'b1; end
                6'b101000: begin w_code = EXE_SB_OP;  w_mem = 1'b1; end
                6'b101001: begin w_code = EXE_SH_OP;  w_mem = 1'b1; end
                6'b101011: begin w_code = EXE_SW_OP;  w_mem = 1'b1; end
                default:   w_ri = 1'b1;
            endcase
        end
    end

    assign w_dec.ctrl = CTRL_W'(w_code);
    assign w_dec.ri   = w_ri;
    assign w_dec.br   = w_br;
    assign w_dec.mem  = w_mem;
    assign w_dec.tag  = bus.in_tag;

    assign w_accept = bus.in_valid & ~r_s_valid;
    assign w_drain  = r_m_valid & bus.out_ready;

    // Skid-buffer control: flush outranks every event, S always drains into M first
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= EMPTY;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
        end else if (flush) begin
            r_state   <= EMPTY;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_m       <= w_dec;
                        r_m_valid <= 1'b1;
                        r_state   <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        r_m <= w_dec;
                    end else if (w_accept) begin
                        // EXE stalled: M must stay stable, park the newcomer in S
                        r_s       <= w_dec;
                        r_s_valid <= 1'b1;
                        r_state   <= FULL;
                    end else if (w_drain) begin
                        r_m_valid <= 1'b0;
                        r_state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        r_m       <= r_s;
                        r_s_valid <= 1'b0;
                        r_state   <= ONE;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    r_m_valid <= 1'b0;
                    r_s_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = ~r_s_valid;
    assign bus.out_valid      = r_m_valid;
    assign bus.out_alucontrol = r_m.ctrl;
    assign bus.out_ri         = r_m.ri;
    assign bus.out_is_branch  = r_m.br;
    assign bus.out_is_mem     = r_m.mem;
    assign bus.out_tag        = r_m.tag;
    assign o_dbg_state        = r_state;

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, flow-controlled successor to the combinational ALU-control decoder: takes a full 32-bit MIPS instruction plus a tag (PC) from the ID side, decodes the EXE operation code, reserved-instruction and class flags, and presents them one cycle later to EXE through a valid/ready interface backed by a 2-entry skid buffer. It sits between the ID and EXE pipeline registers and absorbs EXE back-pressure without a combinational ready path.

## Interface
- CTRL_W, 8: width of alucontrol; EXE_*_OP codes from defines.vh, zero-extended if CTRL_W > 8.
- TAG_W, 32: width of the pass-through tag (PC).
- DECODE_REGIMM, 1: 1 = decode op 6'b000001 (BLTZ/BGEZ/BLTZAL/BGEZAL) by rt; 0 = treat as reserved.
- DECODE_COP0, 1: 1 = decode op 6'b010000 (MFC0/MTC0 by rs, ERET by full word 32'h42000018); 0 = treat as reserved.
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept (registered, no comb path from out_ready).
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  tag carried unchanged.
- out_valid  out  1  decoded entry presented.
- out_ready  in  1  EXE accepts.
- out_alucontrol  out  CTRL_W  decoded operation.
- out_ri  out  1  reserved/unrecognised instruction.
- out_is_branch  out  1  branch/jump class (J, JAL, JR, JALR, BEQ, BNE, BGTZ, BLEZ, REGIMM branches).
- out_is_mem  out  1  load/store class (LB, LBU, LH, LHU, LW, SB, SH, SW).
- out_tag  out  TAG_W  tag of presented entry.

## Operation
- Decode (combinational, on in_instr): op = [31:26], rs = [25:21], rt = [20:16], funct = [5:0]. Every op/funct pair of the existing decoder maps to the same EXE_*_OP code.
- in_instr == 32'h0 -> EXE_NOP_OP, ri = 0 (not SLL).
- Any op, funct, rt (REGIMM) or rs (COP0) not listed -> alucontrol = EXE_NOP_OP, ri = 1, class flags 0. Decoder output is never latched/X.
- Storage: main register M (drives out_*) and skid register S; each has a valid bit.
- in_ready = ~S.valid.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- States {EMPTY, ONE (M only), FULL (M+S)}:
  - EMPTY: accept -> ONE (decoded data into M).
  - ONE: accept & drain -> ONE (new into M); accept & ~drain -> FULL (new into S); drain only -> EMPTY.
  - FULL: in_ready = 0; drain -> ONE (S moves to M); else hold.
- Order preserved: S never overtakes M.
- flush = 1: next edge M.valid = S.valid = 0; any accept that cycle is discarded; flush dominates all events.
- Data fields of M hold stable while out_valid & ~out_ready.

## Timing
- Reset (resetn = 0, async): out_valid 0, in_ready 1, out_alucontrol 0, out_ri 0, out_is_branch 0, out_is_mem 0, out_tag 0; state EMPTY. Reset mid-transfer drops both entries.
- Latency: accept in cycle N -> out_valid with that entry in N+1 (from EMPTY or ONE-with-drain).
- Throughput: 1 instr/cycle with out_ready held 1.
- Back-pressure: one extra entry absorbed after out_ready drops; in_ready falls the following cycle, returns 1 the cycle after the drain from FULL.
- After flush edge: out_valid 0, in_ready 1.

## Test plan
- Reset then stream, out_ready = 1: ADDU (op 0, funct 6'b100001), ORI (op 6'b001101), LW (op 6'b100011) accepted cycles 1-3 -> out_valid cycles 2-4 with EXE_ADDU_OP, EXE_ORI_OP, EXE_LW_OP; is_mem only on LW; tags match.
- Back-pressure: out_ready = 0 while feeding ADD then SUB -> M=ADD, S=SUB, in_ready 0; third instr held by source; out_ready = 1 -> ADD, SUB, third out in order, no loss or duplicate.
- Reserved: op 6'b111111 and op 0 funct 6'b000001 -> EXE_NOP_OP, ri = 1; in_instr = 32'h0 -> EXE_NOP_OP, ri = 0.
- REGIMM/COP0: BGEZAL (op 1, rt 5'b10001) -> is_branch 1, ri 0; ERET 32'h42000018 -> ri 0; rerun with DECODE_REGIMM = 0 -> same BGEZAL gives ri = 1.
- Flush in FULL with in_valid = 1 -> next cycle out_valid 0, in_ready 1, offered instr not output.
- Async reset asserted mid-cycle while FULL -> out_valid 0 immediately, all outputs 0; first accept after release appears 1 cycle later.
